// File: rtl/fixed_point_alu_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fixed_point_alu_arbiter : round-robin sharing of one fixed-point datapath
// between two requesters, with a tagged, backpressured response channel.
// Revision: 1.0
// ----------------------------------------------------------------------------
module fixed_point_alu_arbiter #(
  parameter int W_IN = 17,
  parameter int LAT  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_op0,
  input  logic [1:0]          req_op1,
  input  logic [W_IN-1:0]     req_a0,
  input  logic [W_IN-1:0]     req_a1,
  input  logic [W_IN-1:0]     req_b0,
  input  logic [W_IN-1:0]     req_b1,
  output logic [W_IN-1:0]     alu_a,
  output logic [W_IN-1:0]     alu_b,
  output logic                alu_valid,
  input  logic [W_IN:0]       alu_sum,
  input  logic [W_IN:0]       alu_diff,
  input  logic [2*W_IN:0]     alu_product,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [2*W_IN:0]     rsp_data,
  output logic                rsp_err
);

  localparam int CNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam int W_OUT = 2 * W_IN + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               last_served;
  logic [1:0]         op_q;
  logic               id_q;
  logic               grant_id;
  logic               accept;
  logic               capture;
  logic               handshake;
  logic [W_OUT-1:0]   result;

  // With both requesters pending, the one not served last wins.
  always_comb begin
    grant_id = (req_valid == 2'b11) ? ~last_served : req_valid[1];
    accept   = (state == S_IDLE) && (|req_valid) && !rst;
    if (accept) begin
      req_ready = grant_id ? 2'b10 : 2'b01;
    end else begin
      req_ready = 2'b00;
    end
  end

  assign capture   = (state == S_WAIT) && (cnt == '0);
  assign handshake = (state == S_RESP) && rsp_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)    state_nxt = S_WAIT;
      S_WAIT:  if (capture)   state_nxt = S_RESP;
      S_RESP:  if (handshake) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Results pass through untouched; sum/diff only need sign extension.
  always_comb begin
    case (op_q)
      2'd0:    result = {{W_IN{alu_sum[W_IN]}}, alu_sum};
      2'd1:    result = {{W_IN{alu_diff[W_IN]}}, alu_diff};
      2'd2:    result = alu_product;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      last_served <= 1'b1;
      op_q        <= 2'd0;
      id_q        <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_valid   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
    end else begin
      alu_valid <= accept;
      if (accept) begin
        alu_a <= grant_id ? req_a1 : req_a0;
        alu_b <= grant_id ? req_b1 : req_b0;
        op_q  <= grant_id ? req_op1 : req_op0;
        id_q  <= grant_id;
        cnt   <= CNT_W'(LAT);
      end else if ((state == S_WAIT) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (capture) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        rsp_data  <= result;
        rsp_err   <= (op_q == 2'd3);
      end
      if (handshake) begin
        rsp_valid   <= 1'b0;
        last_served <= rsp_id;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/fixed_point_alu_arbiter.md
Name: fixed_point_alu_arbiter

Overview:
- Shares one fixed_point_arthematic datapath between two requesters.
- Requesters submit an operand pair plus an op code (add, sub, mul). A round-robin arbiter grants one requester, and the block presents its operands to the datapath.
- The block waits out the datapath pipeline latency, selects the requested result, and returns it on a single tagged response channel with backpressure.
- Exactly one transaction is in flight at a time.

Parameters:
- W_IN, 17, operand width (signed, matches operand_1/operand_2)
- LAT, 1, datapath latency in clock edges from operand change to valid sum/diff/product (0 = combinational datapath)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester accept strobe (one-hot or zero)
- req_op0, req_op1  in  2 each  op code: 0 add, 1 sub, 2 mul, 3 reserved
- req_a0, req_a1  in  W_IN each  signed operand_1 per requester
- req_b0, req_b1  in  W_IN each  signed operand_2 per requester
- alu_a  out  W_IN  registered operand_1 to datapath
- alu_b  out  W_IN  registered operand_2 to datapath
- alu_valid  out  1  one-cycle pulse, first cycle after new operands
- alu_sum  in  W_IN+1  datapath sum
- alu_diff  in  W_IN+1  datapath diff
- alu_product  in  2*W_IN+1  datapath product
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer ready
- rsp_id  out  1  requester index of the response
- rsp_data  out  2*W_IN+1  signed result
- rsp_err  out  1  reserved op code flagged

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, cnt=0, last_served=1 (so requester 0 wins first).
  - All registered outputs are 0: rsp_valid, rsp_id, rsp_data, rsp_err, alu_a, alu_b, alu_valid.
  - req_ready=0 during any cycle with rst=1.
  - Reset mid-transaction abandons it; no response is ever produced for it.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Grant rule: if exactly one req_valid bit is set, that requester wins. If both are set, the winner is the one that is not last_served.
  - req_ready[winner]=1 combinationally in this cycle only.
  - Accept edge actions: load alu_a/alu_b from the winner's operands, latch op and id, cnt<=LAT, go to WAIT.
  - req_valid may drop without acceptance; there is no penalty.
  - Request fields are sampled only at the accept edge.
- WAIT:
  - alu_valid=1 in the first WAIT cycle only.
  - If cnt!=0: cnt decrements each cycle.
  - If cnt==0: capture the result at the end of the cycle and go to RESP.
  - Result capture by op:
    - add: alu_sum sign-extended to 2*W_IN+1.
    - sub: alu_diff sign-extended.
    - mul: alu_product.
    - reserved (3): rsp_data=0 and rsp_err=1.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err are held stable until rsp_ready=1.
  - On the handshake edge: last_served<=rsp_id, rsp_valid<=0, go to IDLE.
  - req_ready=0 throughout RESP; there is no same-cycle re-accept.
- Timing: rsp_valid rises LAT+1 cycles after the accept edge. Minimum issue interval is LAT+3 cycles.
- alu_a/alu_b hold their values between transactions; they change only at accept or reset.
- No arithmetic is performed here. Q-format alignment and overflow behaviour belong to the datapath; results pass through bit-exact apart from sign extension.

Test Plan:
Bench uses a datapath stub with LAT register stages: sum=a+b, diff=a-b, product=a*b.
1. Reset, then req0 add with a=100, b=-30 -> req_ready=2'b01 for one cycle; rsp_valid 2 cycles after accept (LAT=1); rsp_id=0, rsp_data=70, rsp_err=0.
2. req1 sub a=100, b=-30 -> rsp_data=130. req0 mul a=-200, b=300 -> rsp_data=-60000. Also mul a=-65536, b=-65536 -> 4294967296, and add 65535+65535 -> 131070.
3. Both req_valid held high with rsp_ready=1 -> grant sequence 0,1,0,1 across four transactions; each response's rsp_id matches the granted requester.
4. rsp_ready=0 for 5 cycles while in RESP -> rsp_valid, rsp_id and rsp_data stable, req_ready=2'b00 throughout. Raising rsp_ready completes the handshake, and the next accept occurs one cycle later.
5. req0 op=3 -> rsp_err=1, rsp_data=0. The next valid op returns rsp_err=0.
6. rst asserted for 1 cycle during WAIT -> next cycle state=IDLE with all outputs 0, and no response ever appears for the abandoned op. Then both requesters valid -> requester 0 granted first.
